fsm_burst_check: RTL

Parametrised burst loopback checker for the FX3 test path. On `ena`, the block drives `BURST_LEN` pattern words, one at a time, with an `intr`/`ack` handshake per word, and compares each returned word on `data_in`. It counts mismatches, aborts on an `ack` timeout, and reports pass/fail on `specreg` with `stop` marking end of run. It sits between the test controller and the FX3 data bus.

---
 rtl/fsm_burst_check.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fsm_burst_check.sv
// Burst loopback checker: sends BURST_LEN pattern words over an intr/ack
// handshake, compares each echoed word and reports pass/fail at end of run.
module fsm_burst_check #(
  parameter int DATA_W       = 23,
  parameter int BURST_LEN    = 4,
  parameter int PATTERN_BASE = 65535,
  parameter int PATTERN_STEP = 1,
  parameter int TIMEOUT      = 255,
  parameter int ERR_CNT_W    = 8,
  localparam int IDX_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 ena,
  input  logic                 ack,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 intr,
  output logic [DATA_W-1:0]    data_out,
  output logic                 stop,
  output logic                 specreg,
  output logic                 timeout_flag,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [IDX_W-1:0]     word_idx
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]     TMO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT    = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic                  intr_reg, intr_next;
  logic [DATA_W-1:0]     data_out_reg, data_out_next;
  logic                  stop_reg, stop_next;
  logic                  specreg_reg, specreg_next;
  logic                  timeout_reg, timeout_next;
  logic [ERR_CNT_W-1:0]  err_cnt_reg, err_cnt_next;
  logic [IDX_W-1:0]      word_idx_reg, word_idx_next;
  logic [TMR_W-1:0]      timer_reg, timer_next;
  logic [DATA_W-1:0]     capt_reg, capt_next;
  logic [IDX_W-1:0]      idx_inc;
  logic                  go_idle;

  // Pattern words are elaboration-time constants, wrapped to DATA_W bits.
  logic [DATA_W-1:0] pattern_tbl [BURST_LEN];
  genvar gi;
  generate
    for (gi = 0; gi < BURST_LEN; gi++) begin : g_pat
      assign pattern_tbl[gi] = DATA_W'(PATTERN_BASE) + DATA_W'(gi) * DATA_W'(PATTERN_STEP);
    end
  endgenerate

  assign idx_inc = word_idx_reg + IDX_W'(1);

  always_comb begin
    state_next    = state_reg;
    intr_next     = 1'b0;
    data_out_next = data_out_reg;
    stop_next     = stop_reg;
    specreg_next  = specreg_reg;
    timeout_next  = timeout_reg;
    err_cnt_next  = err_cnt_reg;
    word_idx_next = word_idx_reg;
    timer_next    = '0;
    capt_next     = capt_reg;
    go_idle       = 1'b0;
    case (state_reg)
      IDLE: begin
        stop_next     = 1'b0;
        specreg_next  = 1'b1;
        data_out_next = '0;
        if (ena) begin
          state_next    = LOAD;
          err_cnt_next  = '0;
          timeout_next  = 1'b0;
          word_idx_next = '0;
          intr_next     = 1'b1;
          data_out_next = pattern_tbl[0];
        end
      end
      LOAD: begin
        if (!ena) go_idle = 1'b1;
        else      state_next = WAIT;
      end
      WAIT: begin
        if (!ena) begin
          go_idle = 1'b1;
        end else if (ack) begin
          capt_next  = data_in;
          state_next = COMPARE;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
          if (TIMEOUT != 0 && timer_reg == TMO_LAST) begin
            state_next   = DONE;
            timeout_next = 1'b1;
            stop_next    = 1'b1;
            specreg_next = 1'b1;
          end
        end
      end
      COMPARE: begin
        if (!ena) begin
          go_idle = 1'b1;
        end else begin
          if (capt_reg != data_out_reg && err_cnt_reg != ERR_MAX)
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
          if (word_idx_reg == IDX_LAST) begin
            state_next   = DONE;
            stop_next    = 1'b1;
            specreg_next = (err_cnt_next != '0) || timeout_reg;
          end else begin
            state_next    = LOAD;
            word_idx_next = idx_inc;
            intr_next     = 1'b1;
            data_out_next = pattern_tbl[idx_inc];
          end
        end
      end
      DONE: begin
        if (!ena) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
    // Aborts and run exits land in IDLE with its output values already set.
    if (go_idle) begin
      state_next    = IDLE;
      intr_next     = 1'b0;
      stop_next     = 1'b0;
      specreg_next  = 1'b1;
      data_out_next = '0;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_reg    <= IDLE;
      intr_reg     <= 1'b0;
      data_out_reg <= '0;
      stop_reg     <= 1'b0;
      specreg_reg  <= 1'b1;
      timeout_reg  <= 1'b0;
      err_cnt_reg  <= '0;
      word_idx_reg <= '0;
      timer_reg    <= '0;
      capt_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      intr_reg     <= intr_next;
      data_out_reg <= data_out_next;
      stop_reg     <= stop_next;
      specreg_reg  <= specreg_next;
      timeout_reg  <= timeout_next;
      err_cnt_reg  <= err_cnt_next;
      word_idx_reg <= word_idx_next;
      timer_reg    <= timer_next;
      capt_reg     <= capt_next;
    end
  end

  assign intr         = intr_reg;
  assign data_out     = data_out_reg;
  assign stop         = stop_reg;
  assign specreg      = specreg_reg;
  assign timeout_flag = timeout_reg;
  assign err_cnt      = err_cnt_reg;
  assign word_idx     = word_idx_reg;

endmodule
